// File: rtl/gol_pkg.sv
// gol_pkg: shared constants and types for the Game of Life display bank.
// Grid geometry, cell width, bank depth (two full grids), FSM state encoding.
package gol_pkg;

   localparam int GRID_X_W   = 8;
   localparam int GRID_Y_W   = 8;
   localparam int SPECIES_W  = 5;
   localparam int BANK_DEPTH = 2 ** (GRID_X_W + GRID_Y_W + 1);

   localparam logic [SPECIES_W-1:0] SPECIES_DEAD = 5'd0;

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_CLEAR   = 2'd1,
      ST_FILL    = 2'd2,
      ST_PENDING = 2'd3
   } bank_state_t;

endpackage

// File: rtl/gol_dp_ram.sv
// gol_dp_ram: simple dual-port RAM, one write port, one registered read port.
// Read data appears one cycle after the address is presented.
module gol_dp_ram
   import gol_pkg::*;
#(
   parameter int DEPTH = BANK_DEPTH,
   parameter int DW    = SPECIES_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:DEPTH-1];
   logic [DW-1:0] r_rdata;

   // Write port: store one word per enabled cycle.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: register the addressed word (1-cycle latency), zero out of reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/gol_display_bank.sv
// gol_display_bank: double-buffered GoL cell store.
// Engine writes the back half through valid/ready, video reads the front half.
// Halves swap only at frame_start after a whole generation has been committed.
// Optional macro GOL_BANK_CLEAR_EN: clear all RAM words to dead after reset.
module gol_display_bank
   import gol_pkg::*;
#(
   parameter int GRID_X_W  = gol_pkg::GRID_X_W,
   parameter int GRID_Y_W  = gol_pkg::GRID_Y_W,
   parameter int SPECIES_W = gol_pkg::SPECIES_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [GRID_Y_W+GRID_X_W-1:0] rd_addr,
   output logic [SPECIES_W-1:0]         rd_data,
   input  logic                         frame_start,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [SPECIES_W-1:0]         wr_data,
   input  logic                         wr_last,
   output logic                         front_sel,
   output logic                         swap_pulse,
   output logic                         wr_err
);

   localparam int CAW = GRID_Y_W + GRID_X_W;   // cell address width
   localparam int BAW = CAW + 1;               // bank address width

   bank_state_t           r_state;
   bank_state_t           w_state_nxt;
   logic [CAW-1:0]        r_wcnt;
   logic                  r_front_sel;
   logic                  r_swap_pulse;
   logic                  r_wr_err;
   logic                  r_wr_ready;
   logic                  w_accept;
   logic                  w_swap;
   logic                  w_ram_we;
   logic [BAW-1:0]        w_ram_waddr;
   logic [SPECIES_W-1:0]  w_ram_wdata;
   logic [SPECIES_W-1:0]  w_ram_q;
`ifdef GOL_BANK_CLEAR_EN
   logic [BAW-1:0]        r_ccnt;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: fill until wr_last, then hold until a frame boundary.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: begin
`ifdef GOL_BANK_CLEAR_EN
            w_state_nxt = ST_CLEAR;
`else
            w_state_nxt = ST_FILL;
`endif
         end
         ST_CLEAR: begin
`ifdef GOL_BANK_CLEAR_EN
            if (&r_ccnt) begin
               w_state_nxt = ST_FILL;
            end else begin
               w_state_nxt = ST_CLEAR;
            end
`else
            w_state_nxt = ST_FILL;
`endif
         end
         ST_FILL: begin
            if (w_accept && wr_last) begin
               w_state_nxt = ST_PENDING;
            end else begin
               w_state_nxt = ST_FILL;
            end
         end
         ST_PENDING: begin
            if (frame_start) begin
               w_state_nxt = ST_FILL;
            end else begin
               w_state_nxt = ST_PENDING;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   // Output decode: beat acceptance, swap request, RAM write-port mux.
   always_comb begin
      w_accept    = wr_valid && r_wr_ready;
      w_swap      = (r_state == ST_PENDING) && frame_start;
      w_ram_we    = w_accept;
      w_ram_waddr = {~r_front_sel, r_wcnt};
      w_ram_wdata = wr_data;
`ifdef GOL_BANK_CLEAR_EN
      if (r_state == ST_CLEAR) begin
         w_ram_we    = 1'b1;
         w_ram_waddr = r_ccnt;
         w_ram_wdata = SPECIES_DEAD;
      end else begin
         w_ram_we    = w_accept;
      end
`endif
   end

   // Registered outputs and write counter; wr_err flags a wr_last/wrap misalignment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ready   <= 1'b0;
         r_swap_pulse <= 1'b0;
         r_front_sel  <= 1'b0;
         r_wr_err     <= 1'b0;
         r_wcnt       <= '0;
      end else begin
         r_wr_ready   <= (w_state_nxt == ST_FILL);
         r_swap_pulse <= w_swap;
         if (w_swap) begin
            r_front_sel <= ~r_front_sel;
         end
         if (w_accept) begin
            if (wr_last != (&r_wcnt)) begin
               r_wr_err <= 1'b1;
            end
            if (wr_last) begin
               r_wcnt <= '0;
            end else begin
               r_wcnt <= r_wcnt + {{(CAW-1){1'b0}}, 1'b1};
            end
         end
      end
   end

`ifdef GOL_BANK_CLEAR_EN
   // Clear address counter walks every bank word once while in CLEAR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ccnt <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_ccnt <= r_ccnt + {{(BAW-1){1'b0}}, 1'b1};
      end
   end
`endif

   gol_dp_ram #(
      .DEPTH (2 ** BAW),
      .DW    (SPECIES_W),
      .AW    (BAW)
   ) u_ram (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_raddr ({r_front_sel, rd_addr}),
      .o_rdata (w_ram_q)
   );

`ifdef GOL_BANK_CLEAR_EN
   assign rd_data = (r_state == ST_CLEAR) ? SPECIES_DEAD : w_ram_q;
`else
   assign rd_data = w_ram_q;
`endif
   assign wr_ready   = r_wr_ready;
   assign front_sel  = r_front_sel;
   assign swap_pulse = r_swap_pulse;
   assign wr_err     = r_wr_err;

endmodule

// File: doc/gol_display_bank.md
# gol_display_bank

Double-buffered cell store on the other side of the display-bank read interface used by the Game of Life video source. The GoL engine streams each new generation into the back buffer through a valid/ready port. The video pipeline reads the front buffer with fixed 1-cycle latency. Front and back swap only at a frame-start pulse, and only after a full generation has been committed, so no frame ever shows a half-written grid.

## Interface
Parameters:
- GRID_X_W, 8, column index width (256 columns)
- GRID_Y_W, 8, row index width (256 rows)
- SPECIES_W, 5, cell value width (0 = dead, 1..31 = species)

Ports:
- clk  in  1  single clock (pixel clock domain)
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  16  {y[7:0], x[7:0]} read address from the video source
- rd_data  out  5  front-buffer cell at the previous cycle's rd_addr
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- wr_valid  in  1  engine presents a cell
- wr_ready  out  1  bank accepts a cell
- wr_data  in  5  cell value, raster order
- wr_last  in  1  marks the final cell of a generation
- front_sel  out  1  index of the buffer currently displayed
- swap_pulse  out  1  one-cycle pulse when a swap takes effect
- wr_err  out  1  sticky flag: wr_last arrived at a misaligned position

## Operation
- Storage is one 2^17 × 5 RAM. Reads use {front_sel, rd_addr}. Writes use {~front_sel, wcnt}.
- States:
  - INIT: the cycle after reset release.
  - CLEAR: present only with the macro; see Configuration.
  - FILL: wr_ready=1.
  - PENDING: wr_ready=0, waiting for frame_start.
- A beat is accepted when wr_valid && wr_ready. wcnt (16 bits) increments on every accepted beat and wraps from 65535 to 0.
- Accepted beat with wr_last=1:
  - wcnt returns to 0.
  - State goes to PENDING.
  - If wcnt != 65535 on that beat, wr_err is set. The beat is still written.
- Accepted beat with wcnt=65535 and wr_last=0: wcnt wraps to 0, state stays FILL, wr_err is set.
- PENDING and frame_start=1: front_sel toggles, swap_pulse=1 for one cycle, state returns to FILL.
- frame_start in FILL, INIT or CLEAR is ignored.
- wr_last accepted in the same cycle as frame_start: no swap on that frame. The swap happens on the next frame_start.
- wr_err clears only on reset.
- Reset asserted mid-generation discards the partial write. The front buffer keeps its RAM contents, but front_sel returns to 0.

## Timing
- Reset values: rd_data=0, wr_ready=0, front_sel=0, swap_pulse=0, wr_err=0, wcnt=0, state INIT.
- INIT lasts one cycle, then goes to FILL (or CLEAR if the macro is defined). wr_ready first goes high 1 cycle after rst_n deasserts (no-macro build).
- wr_ready is a registered decode of state; it does not depend on wr_valid.
- Read latency is exactly 1 cycle: rd_addr at cycle N gives rd_data at N+1.
- The swap is registered at the frame_start cycle N:
  - front_sel changes at N+1.
  - Reads issued at N+1 or later see the new front; their data appears at N+2.
- wr_ready drops in the cycle after the wr_last beat. Throughput is 1 cell/cycle in FILL.
- A read and a write in the same cycle never collide, because they always target different halves.

## Configuration
- GOL_BANK_CLEAR_EN defined:
  - After INIT the block enters CLEAR and writes 0 to all 131072 RAM words, one per cycle.
  - wr_ready=0 and rd_data=0 throughout CLEAR. FILL starts the cycle after the last clear write.
  - The first displayed frame is all dead (species 0).
- Not defined: no CLEAR state. RAM contents are whatever the device initialises them to.

## Structure
- gol_pkg holds:
  - GRID_X_W, GRID_Y_W, SPECIES_W, BANK_DEPTH (2^17).
  - the state enum (INIT, CLEAR, FILL, PENDING).
  - the dead-cell constant SPECIES_DEAD = 0.
- One sub-module, gol_dp_ram: simple dual-port RAM with one write port and one registered read port (1-cycle latency), depth BANK_DEPTH, width SPECIES_W.

## Test plan
- Reset, then stream 65536 cells with value (addr[4:0]) and wr_last on the final beat, pulse frame_start, read addr 0x0105 → rd_data=5 one cycle later, swap_pulse once, front_sel=1.
- Complete a generation with no frame_start → wr_ready stays 0, front_sel unchanged, reads still return the old front data.
- wr_last and frame_start in the same cycle → no swap. Next frame_start → swap_pulse, front_sel toggles.
- wr_last at beat 100 → wr_err=1 and stays 1. Next generation writes start at wcnt=0.
- rst_n low in the middle of a generation → wr_ready=0, front_sel=0, wr_err=0 immediately. One cycle after release, FILL.
- With GOL_BANK_CLEAR_EN: wr_ready rises exactly 131073 cycles after INIT. Reading any address returns 0.
